// File: rtl/ps2_key_decoder_pkg.sv
// Scan-code constants and receiver state encoding shared by the
// PS/2 keyboard receiver and the prefix/held-key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] KEY_W    = 8'h1D;
    localparam logic [7:0] KEY_S    = 8'h1B;
    localparam logic [7:0] KEY_UP   = 8'h75;
    localparam logic [7:0] KEY_DOWN = 8'h72;
    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_t;

    function automatic logic key_is(
        input key_t       k,
        input logic       ext,
        input logic [7:0] code
    );
        return (k.ext == ext) && (k.code == code);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter,
// start/data/parity/stop FSM and a saturating inactivity timeout.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);
    import ps2_key_decoder_pkg::*;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_s;
    logic [1:0]    dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          strobe;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            clk_s  <= 2'b11;
            dat_s  <= 2'b11;
            filt   <= 1'b1;
            fcnt   <= '0;
            strobe <= 1'b0;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            dat_s  <= {dat_s[0], ps2_data};
            strobe <= 1'b0;
            if (clk_s[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FLAST) begin
                filt   <= clk_s[1];
                fcnt   <= '0;
                // only a 1->0 transition of the filtered clock strobes
                strobe <= filt;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bitcnt      <= 3'd0;
            shreg       <= 8'h00;
            par         <= 1'b0;
            tcnt        <= '0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (strobe) begin
                tcnt <= '0;
            end else if (tcnt != TMAX) begin
                tcnt <= tcnt + 1'b1;
            end
            if (strobe) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!dat_s[1]) begin
                            state  <= ST_DATA;
                            bitcnt <= 3'd0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg  <= {dat_s[1], shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= dat_s[1];
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_s[1] && (^shreg ^ par)) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE && tcnt == TMAX) begin
                state       <= ST_IDLE;
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: E0/F0 prefix tracking, held levels for both
// paddles and one-cycle menu pulses, fed by the ps2_rx receiver.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       start_trigger,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);
    import ps2_key_decoder_pkg::*;

    logic ext;
    logic brk;
    key_t key;
    logic is_w;
    logic is_s;
    logic is_u;
    logic is_d;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_0      (clk_0),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_error(frame_error)
    );

    assign key  = {ext, scan_code};
    assign is_w = key_is(key, 1'b0, KEY_W);
    assign is_s = key_is(key, 1'b0, KEY_S);
    assign is_u = key_is(key, 1'b1, KEY_UP);
    assign is_d = key_is(key, 1'b1, KEY_DOWN);

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            ext           <= 1'b0;
            brk           <= 1'b0;
            up            <= 1'b0;
            down          <= 1'b0;
            start_trigger <= 1'b0;
            p1_up         <= 1'b0;
            p1_down       <= 1'b0;
            p2_up         <= 1'b0;
            p2_down       <= 1'b0;
        end else begin
            up            <= 1'b0;
            down          <= 1'b0;
            start_trigger <= 1'b0;
            if (frame_error) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (scan_valid) begin
                if (scan_code == PFX_EXT) begin
                    ext <= 1'b1;
                end else if (scan_code == PFX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
                        if (is_w) p1_up   <= 1'b0;
                        if (is_s) p1_down <= 1'b0;
                        if (is_u) p2_up   <= 1'b0;
                        if (is_d) p2_down <= 1'b0;
                    end else begin
                        start_trigger <= 1'b1;
                        // edge against the old level so repeats stay silent
                        up   <= (is_w && !p1_up) || (is_u && !p2_up);
                        down <= (is_s && !p1_down) || (is_d && !p2_down);
                        if (is_w) p1_up   <= 1'b1;
                        if (is_s) p1_down <= 1'b1;
                        if (is_u) p2_up   <= 1'b1;
                        if (is_d) p2_down <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives PS/2 frames into ps2_key_decoder and checks pulse counts,
// held levels and timing against a byte-level reference model.
module tb_ps2_key_decoder;

    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int HP = 20;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up;
    logic       down;
    logic       start_trigger;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    int vectors = 0;
    int miscompares = 0;

    int n_up = 0, n_down = 0, n_st = 0, n_sv = 0, n_err = 0;
    int e_up = 0, e_down = 0, e_st = 0, e_sv = 0, e_err = 0;
    logic [3:0] e_held = 4'h0;
    logic [7:0] e_code = 8'h00;
    bit m_ext = 0;
    bit m_brk = 0;

    logic       sv_q = 1'b0;
    logic       rst_q = 1'b0;
    logic [3:0] held_q = 4'h0;
    logic [3:0] held;

    assign held = {p2_down, p2_up, p1_down, p1_up};

    ps2_key_decoder #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_0        (clk_0),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .up           (up),
        .down         (down),
        .start_trigger(start_trigger),
        .p1_up        (p1_up),
        .p1_down      (p1_down),
        .p2_up        (p2_up),
        .p2_down      (p2_down),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .frame_error  (frame_error)
    );

    always #5 clk_0 = ~clk_0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_0) begin
        if (rst && rst_q) begin
            n_up   += int'(up);
            n_down += int'(down);
            n_st   += int'(start_trigger);
            n_sv   += int'(scan_valid);
            n_err  += int'(frame_error);
            if (up || down || start_trigger)
                chk("pulse_after_valid", 32'(sv_q), 32'd1);
            if (held != held_q)
                chk("held_after_valid", 32'(sv_q), 32'd1);
        end
        sv_q   = scan_valid;
        held_q = held;
        rst_q  = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_0);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HP);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
    endtask

    function automatic int key_idx(input bit x, input logic [7:0] b);
        if (!x && b == 8'h1D) return 0;
        if (!x && b == 8'h1B) return 1;
        if (x && b == 8'h75)  return 2;
        if (x && b == 8'h72)  return 3;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit good);
        int k;
        if (!good) begin
            e_err++;
            m_ext = 0;
            m_brk = 0;
            return;
        end
        e_sv++;
        e_code = b;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = key_idx(m_ext, b);
            if (m_brk) begin
                if (k >= 0) e_held[k] = 1'b0;
            end else begin
                e_st++;
                if (k >= 0) begin
                    if (!e_held[k]) begin
                        if (k == 0 || k == 2) e_up++;
                        else e_down++;
                    end
                    e_held[k] = 1'b1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".up"}, 32'(n_up), 32'(e_up));
        chk({tag, ".down"}, 32'(n_down), 32'(e_down));
        chk({tag, ".start"}, 32'(n_st), 32'(e_st));
        chk({tag, ".valid"}, 32'(n_sv), 32'(e_sv));
        chk({tag, ".error"}, 32'(n_err), 32'(e_err));
        chk({tag, ".held"}, 32'(held), 32'(e_held));
        chk({tag, ".code"}, 32'(scan_code), 32'(e_code));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input string tag);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        tick(15);
        model_byte(b, !(bad_par || bad_stop));
        check_all(tag);
    endtask

    initial begin
        logic [7:0] tbl [0:5];
        logic [7:0] b;
        int r;
        tbl[0] = 8'h1D; tbl[1] = 8'h1B; tbl[2] = 8'h75;
        tbl[3] = 8'h72; tbl[4] = 8'hE0; tbl[5] = 8'hF0;

        tick(5);
        chk("reset_outs",
            {20'h0, up, down, start_trigger, p1_up, p1_down, p2_up,
             p2_down, scan_valid, frame_error, 3'b0}, 32'h0);
        chk("reset_code", 32'(scan_code), 32'h0);
        rst = 1'b1;
        tick(5);

        send_frame(8'h1D, 0, 0, "w_make");
        send_frame(8'h1D, 0, 0, "w_rep1");
        send_frame(8'h1D, 0, 0, "w_rep2");
        send_frame(8'hF0, 0, 0, "w_brk_pfx");
        send_frame(8'h1D, 0, 0, "w_brk");
        send_frame(8'h1D, 0, 0, "w_again");
        send_frame(8'hE0, 0, 0, "up_pfx");
        send_frame(8'h75, 0, 0, "up_make");
        send_frame(8'hE0, 0, 0, "dn_pfx");
        send_frame(8'h72, 0, 0, "dn_make");
        send_frame(8'hE0, 0, 0, "dn_pfx2");
        send_frame(8'hF0, 0, 0, "dn_brk_pfx");
        send_frame(8'h72, 0, 0, "dn_brk");
        send_frame(8'h1B, 1, 0, "bad_parity");
        send_frame(8'h1B, 0, 1, "bad_stop");

        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        tick(TO + 40);
        model_byte(8'h00, 0);
        check_all("timeout");
        send_frame(8'h1B, 0, 0, "s_after_to");

        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(30);
        check_all("glitch");

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        tick(2);
        chk("midrst_outs",
            {20'h0, up, down, start_trigger, p1_up, p1_down, p2_up,
             p2_down, scan_valid, frame_error, 3'b0}, 32'h0);
        chk("midrst_code", 32'(scan_code), 32'h0);
        e_held = 4'h0;
        e_code = 8'h00;
        m_ext = 0;
        m_brk = 0;
        ps2_data = 1'b1;
        rst = 1'b1;
        tick(10);
        send_frame(8'h1B, 0, 0, "s_after_rst");

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 7));
            if (r < 6) b = tbl[r];
            else b = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            send_frame(b, r == 0, r == 1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
